// File: rtl/md5_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md5_pkg: shared MD5 block constants, charset and builder state enum  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package md5_pkg;

   localparam int          BLOCK_W      = 512;
   localparam logic [7:0]  MD5_PAD_BYTE = 8'h80;
   localparam int          BASE         = 26;
   localparam logic [7:0]  BASE_CHAR    = 8'h61;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      HOLD    = 2'd2
   } state_t;

   // Everything in the block except the characters: pad byte and 64-bit bit length.
   function automatic logic [BLOCK_W-1:0] pad_tail(input int pw_len);
      logic [BLOCK_W-1:0] blk;
      blk                     = '0;
      blk[8*pw_len +: 8]      = MD5_PAD_BYTE;
      blk[BLOCK_W-1 -: 64]    = 64'(pw_len * 8);
      return blk;
   endfunction

endpackage
`default_nettype wire

// File: rtl/candidate_builder_radix_digit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | radix_digit: combinational divide by a constant radix                |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module radix_digit #(
   parameter int IDX_W = 29,
   parameter int BASE  = 26
) (
   input  logic [IDX_W-1:0] dividend,
   output logic [IDX_W-1:0] quotient,
   output logic [IDX_W-1:0] remainder
);

   localparam logic [IDX_W-1:0] c_base = IDX_W'(BASE);

   assign quotient  = dividend / c_base;
   assign remainder = dividend % c_base;

endmodule
`default_nettype wire

// File: rtl/candidate_builder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | candidate_builder: index -> lowercase password -> padded MD5 block   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module candidate_builder #(
   parameter int         IDX_W     = 29,
   parameter int         PW_LEN    = 7,
   parameter int         BASE      = md5_pkg::BASE,
   parameter logic [7:0] BASE_CHAR = md5_pkg::BASE_CHAR
) (
   input  logic                        CLK,
   input  logic                        reset,
   input  logic [IDX_W-1:0]            in_index,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [md5_pkg::BLOCK_W-1:0] out_block,
   output logic [IDX_W-1:0]            out_index,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        overflow,
   output logic                        busy
);
   import md5_pkg::*;

   localparam int                 K_W      = (PW_LEN > 1) ? $clog2(PW_LEN) : 1;
   localparam logic [K_W-1:0]     c_last_k = K_W'(PW_LEN - 1);
   localparam logic [BLOCK_W-1:0] c_pad    = pad_tail(PW_LEN);

   state_t                r_state;
   state_t                w_state_next;
   logic [IDX_W-1:0]      r_work;
   logic [IDX_W-1:0]      r_index;
   logic [K_W-1:0]        r_k;
   logic [8*PW_LEN-1:0]   r_chars;
   logic                  r_overflow;
   logic                  r_pad_en;
   logic [IDX_W-1:0]      w_quot;
   logic [IDX_W-1:0]      w_rem;
   logic                  w_unused_rem;

   radix_digit #(
      .IDX_W (IDX_W),
      .BASE  (BASE)
   ) u_radix_digit (
      .dividend  (r_work),
      .quotient  (w_quot),
      .remainder (w_rem)
   );

   // Only the low byte of the remainder can be nonzero.
   assign w_unused_rem = &{1'b0, w_rem};

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)          w_state_next = CONVERT;
         CONVERT: if (r_k == c_last_k)   w_state_next = HOLD;
         HOLD:    if (out_ready)         w_state_next = IDLE;
         default:                        w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_work     <= '0;
         r_index    <= '0;
         r_k        <= '0;
         r_chars    <= '0;
         r_overflow <= 1'b0;
         r_pad_en   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_work   <= in_index;
                  r_index  <= in_index;
                  r_k      <= '0;
                  r_pad_en <= 1'b1;
               end
            end
            CONVERT: begin
               // Least-significant digit is produced first and lands in the last character.
               r_work                                 <= w_quot;
               r_chars[8*(PW_LEN-1-int'(r_k)) +: 8]   <= BASE_CHAR + 8'(w_rem);
               r_k                                    <= r_k + 1'b1;
               if ((r_k == c_last_k) && (w_quot != '0))
                  r_overflow <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Gated by reset so the upstream never sees ready while the block is held in reset.
   assign in_ready  = (r_state == IDLE) && reset;
   assign out_valid = (r_state == HOLD);
   assign busy      = (r_state != IDLE);
   assign overflow  = r_overflow;
   assign out_index = r_index;
   assign out_block = BLOCK_W'(r_chars) | (r_pad_en ? c_pad : '0);

endmodule
`default_nettype wire

// File: tb/tb_candidate_builder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_candidate_builder: randomized self-checking bench, PW_LEN 7 and 2 |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_candidate_builder;

   localparam int IDX_W = 29;

   logic             clk = 1'b0;
   always #5 clk = ~clk;

   // PW_LEN = 7 instance
   logic             rst_n;
   logic [IDX_W-1:0] in_index;
   logic             in_valid;
   logic             in_ready;
   logic [511:0]     out_block;
   logic [IDX_W-1:0] out_index;
   logic             out_valid;
   logic             out_ready;
   logic             overflow;
   logic             busy;

   // PW_LEN = 2 instance
   logic             rst2_n;
   logic [IDX_W-1:0] in_index2;
   logic             in_valid2;
   logic             in_ready2;
   logic [511:0]     out_block2;
   logic [IDX_W-1:0] out_index2;
   logic             out_valid2;
   logic             out_ready2;
   logic             overflow2;
   logic             busy2;

   candidate_builder #(.IDX_W(IDX_W), .PW_LEN(7)) dut (
      .CLK(clk), .reset(rst_n), .in_index(in_index), .in_valid(in_valid),
      .in_ready(in_ready), .out_block(out_block), .out_index(out_index),
      .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow), .busy(busy)
   );

   candidate_builder #(.IDX_W(IDX_W), .PW_LEN(2)) dut2 (
      .CLK(clk), .reset(rst2_n), .in_index(in_index2), .in_valid(in_valid2),
      .in_ready(in_ready2), .out_block(out_block2), .out_index(out_index2),
      .out_valid(out_valid2), .out_ready(out_ready2), .overflow(overflow2), .busy(busy2)
   );

   int           n_vec = 0;
   int           n_err = 0;
   logic         exp_ovf7 = 1'b0;
   logic         exp_ovf2 = 1'b0;
   logic [511:0] last_blk;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic longint pow26(input int e);
      longint p = 1;
      for (int j = 0; j < e; j++) p = p * 26;
      return p;
   endfunction

   // Character i carries base-26 digit weight 26^(pw-1-i); byte i = block[8i+7:8i].
   function automatic logic [511:0] model_block(input longint idx, input int pw);
      logic [511:0] b = '0;
      for (int i = 0; i < pw; i++)
         b[8*i +: 8] = 8'(64'h61 + (idx / pow26(pw - 1 - i)) % 26);
      b[8*pw +: 8]  = 8'h80;
      b[511:448]    = 64'(pw * 8);
      return b;
   endfunction

   task automatic run7(input logic [IDX_W-1:0] idx, input int hold);
      int           cyc;
      logic [511:0] snap;
      cyc = 0;
      while (!in_ready && cyc < 20) begin @(negedge clk); cyc++; end
      if (!in_ready) check("rdy_timeout", {511'd0, in_ready}, 512'd1);
      in_index = idx;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_index = IDX_W'($urandom);
      cyc = 0;
      while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
      check("latency", 512'(cyc), 512'd7);
      if (longint'(idx) >= pow26(7)) exp_ovf7 = 1'b1;
      check("block", out_block, model_block(longint'(idx), 7));
      check("out_index", 512'(out_index), 512'(idx));
      check("overflow", 512'(overflow), 512'(exp_ovf7));
      snap = out_block;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("bp_valid", 512'(out_valid), 512'd1);
         check("bp_block", out_block, snap);
         check("bp_in_ready", 512'(in_ready), 512'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("post_in_ready", 512'(in_ready), 512'd1);
      check("post_out_valid", 512'(out_valid), 512'd0);
      last_blk = snap;
      @(negedge clk);
   endtask

   task automatic run2(input logic [IDX_W-1:0] idx);
      int cyc;
      cyc = 0;
      while (!in_ready2 && cyc < 20) begin @(negedge clk); cyc++; end
      if (!in_ready2) check("rdy2_timeout", {511'd0, in_ready2}, 512'd1);
      in_index2 = idx;
      in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      cyc = 0;
      while (!out_valid2 && cyc < 40) begin @(posedge clk); #1; cyc++; end
      check("latency2", 512'(cyc), 512'd2);
      if (longint'(idx) >= pow26(2)) exp_ovf2 = 1'b1;
      check("block2", out_block2, model_block(longint'(idx), 2));
      check("len_byte2", 512'(out_block2[455:448]), 512'h10);
      check("out_index2", 512'(out_index2), 512'(idx));
      check("overflow2", 512'(overflow2), 512'(exp_ovf2));
      out_ready2 = 1'b1;
      @(posedge clk); #1;
      out_ready2 = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int acc[$];
      int seen;
      rst_n = 1'b0;  in_index  = '0; in_valid  = 1'b0; out_ready  = 1'b0;
      rst2_n = 1'b0; in_index2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 512'(in_ready), 512'd0);
      check("rst_out_valid", 512'(out_valid), 512'd0);
      check("rst_busy", 512'(busy), 512'd0);
      check("rst_overflow", 512'(overflow), 512'd0);
      check("rst_block", out_block, 512'd0);
      check("rst_index", 512'(out_index), 512'd0);
      @(negedge clk);
      rst_n = 1'b1; rst2_n = 1'b1;
      #1;
      check("rel_in_ready", 512'(in_ready), 512'd1);
      @(negedge clk);

      run7(29'd0, 0);
      check("idx0_byte7", 512'(last_blk[63:56]), 512'h80);
      check("idx0_byte56", 512'(last_blk[455:448]), 512'h38);
      run7(29'd25, 0);
      check("z_byte6", 512'(last_blk[55:48]), 512'h7a);
      run7(29'd26, 0);
      check("ba_bytes56", 512'(last_blk[55:40]), 512'h6162);
      run7(29'h1FFF_FFFF, 0);
      check("max_msd", 512'(last_blk[7:0]), 512'h62);
      run7(IDX_W'($urandom), 10);
      for (int r = 0; r < 16; r++)
         run7(IDX_W'($urandom), int'($urandom_range(0, 3)));

      // Throughput with both sides always willing.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_index  = IDX_W'($urandom);
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (in_valid && in_ready) acc.push_back(c);
      end
      in_valid = 1'b0;
      repeat (12) @(negedge clk);
      out_ready = 1'b0;
      if (acc.size() >= 3) begin
         check("tput_gap1", 512'(acc[1] - acc[0]), 512'd9);
         check("tput_gap2", 512'(acc[2] - acc[1]), 512'd9);
      end else begin
         check("tput_accepts", 512'(acc.size()), 512'd3);
      end
      check("tput_idle", 512'(busy), 512'd0);

      // PW_LEN = 2: overflow sets and stays until reset.
      run2(29'd676);
      run2(29'd5);
      run2(IDX_W'($urandom_range(0, 675)));
      check("ovf2_sticky", 512'(overflow2), 512'd1);
      rst2_n = 1'b0;
      @(posedge clk); #1;
      rst2_n = 1'b1;
      #1;
      check("ovf2_cleared", 512'(overflow2), 512'd0);
      exp_ovf2 = 1'b0;

      // Reset in the middle of a conversion discards the index.
      @(negedge clk);
      in_index = 29'd12345;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_busy", 512'(busy), 512'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("abort_in_ready", 512'(in_ready), 512'd1);
      check("abort_out_valid", 512'(out_valid), 512'd0);
      check("abort_busy", 512'(busy), 512'd0);
      check("abort_overflow", 512'(overflow), 512'd0);
      out_ready = 1'b1;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      out_ready = 1'b0;
      check("abort_no_emit", 512'(seen), 512'd0);

      run7(IDX_W'($urandom), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
